// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store controller for a 64-bit data memory.
// 32-bit stores run as read-modify-write because the memory only writes whole words.
module mem_access_unit #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_dw,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [63:0]       mem_wd,
  input  logic [63:0]       mem_rd
);

  // The datapath is hard-wired for 64-bit memory words.
  generate
    if (DATA_W != 64) begin : g_bad_width
      $error("mem_access_unit: DATA_W must be 64");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE, LD, ST64, RMW_RD, RMW_WR, ERR, RESP
  } state_t;

  state_t            state, state_nxt;
  logic              we_q, dw_q, sg_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q, word_q, rdata_q;
  logic              misaligned;
  logic              we_raw;
  logic [ADDR_W-1:0] aligned_a;

  assign misaligned = req_dw ? (req_addr[2:0] != 3'b000) : (req_addr[1:0] != 2'b00);
  assign aligned_a  = {addr_q[ADDR_W-1:3], 3'b000};

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && err_q;
  assign resp_rdata = rdata_q;
  // Reset must suppress any in-flight write, even in the cycle it is asserted.
  assign mem_we     = we_raw && !reset;

  // Next-state and memory-port decode.
  always_comb begin
    state_nxt = state;
    mem_a     = '0;
    mem_wd    = '0;
    we_raw    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (misaligned)   state_nxt = ERR;
          else if (!req_we) state_nxt = LD;
          else if (req_dw)  state_nxt = ST64;
          else              state_nxt = RMW_RD;
        end
      end
      LD: begin
        // For 32-bit loads with addr[2]=1 the memory's shifted read path
        // already places the upper half of word n in mem_rd[31:0].
        mem_a     = addr_q;
        state_nxt = RESP;
      end
      ST64: begin
        mem_a     = addr_q;
        we_raw    = 1'b1;
        mem_wd    = wdata_q;
        state_nxt = RESP;
      end
      RMW_RD: begin
        mem_a     = aligned_a;
        state_nxt = RMW_WR;
      end
      RMW_WR: begin
        mem_a     = aligned_a;
        we_raw    = 1'b1;
        mem_wd    = addr_q[2] ? {wdata_q[31:0], word_q[31:0]}
                              : {word_q[63:32], wdata_q[31:0]};
        state_nxt = RESP;
      end
      ERR:     state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, request latch, RMW word buffer and response data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      dw_q    <= 1'b0;
      sg_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          dw_q    <= req_dw;
          sg_q    <= req_signed;
          err_q   <= misaligned;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
        end
        LD:      rdata_q <= dw_q ? mem_rd
                                 : {{32{sg_q & mem_rd[31]}}, mem_rd[31:0]};
        RMW_RD:  word_q  <= mem_rd;
        ST64, RMW_WR, ERR: rdata_q <= '0;
        default: ;
      endcase
    end
  end

  // we_q is kept for debug visibility of the accepted request type.
  logic unused_ok;
  assign unused_ok = we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural 4-word memory model.
module tb_mem_access_unit;
  localparam int ADDR_W = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, req_we, req_dw, req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid, resp_err, mem_we;
  logic [63:0]       resp_rdata, mem_wd, mem_rd;
  logic [ADDR_W-1:0] mem_a;

  logic [63:0] mem [0:3];
  int tests = 0;
  int fails = 0;

  // Observations of the last request
  int          o_resp_at, o_we_cnt, o_we_at;
  logic [63:0] o_rdata, o_we_a;
  logic        o_err, o_ready_busy;

  mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(64)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_dw(req_dw), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_a(mem_a),
    .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read with shifted path, write on posedge.
  always_comb begin
    if (mem_a[2]) mem_rd = {mem[mem_a[4:3] + 2'd1][31:0], mem[mem_a[4:3]][63:32]};
    else          mem_rd = mem[mem_a[4:3]];
  end

  always @(posedge clk) if (mem_we) mem[mem_a[4:3]] <= mem_wd;

  task automatic run_req(input logic we, input logic dw, input logic sg,
                         input logic [63:0] addr, input logic [63:0] wd);
    @(negedge clk);
    req_we = we; req_dw = dw; req_signed = sg; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    o_resp_at = 0; o_we_cnt = 0; o_we_at = 0; o_we_a = '0;
    o_rdata = '0; o_err = 1'b0; o_ready_busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 1) o_ready_busy = req_ready;
      if (mem_we) begin
        o_we_cnt++;
        o_we_at = k;
        o_we_a  = mem_a;
      end
      if (resp_valid && o_resp_at == 0) begin
        o_resp_at = k;
        o_rdata   = resp_rdata;
        o_err     = resp_err;
      end
      if (k < 6) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", req_ready); end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    tests++; if (resp_err !== 1'b0) begin fails++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
    tests++; if (resp_rdata !== 64'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
    tests++; if (mem_we !== 1'b0 || mem_a !== 64'h0) begin fails++; $display("FAIL reset_mem got we=%b a=%h want 0/0", mem_we, mem_a); end
  endtask

  task automatic test_load;
    run_req(1'b0, 1'b0, 1'b0, 64'h4, 64'h0);
    tests++; if (o_resp_at !== 2) begin fails++; $display("FAIL ld32z_latency got %0d want 2", o_resp_at); end
    tests++; if (o_rdata !== 64'h0000_0000_1111_2222) begin fails++; $display("FAIL ld32z_data got %h want 0000000011112222", o_rdata); end
    tests++; if (o_we_cnt !== 0) begin fails++; $display("FAIL ld32z_we got %0d want 0", o_we_cnt); end
    tests++; if (o_ready_busy !== 1'b0) begin fails++; $display("FAIL busy_ready got %b want 0", o_ready_busy); end
    run_req(1'b0, 1'b0, 1'b1, 64'h8, 64'h0);
    tests++; if (o_rdata !== 64'hFFFF_FFFF_DEAD_BEEF) begin fails++; $display("FAIL ld32s_data got %h want ffffffffdeadbeef", o_rdata); end
    run_req(1'b0, 1'b0, 1'b1, 64'hC, 64'h0);
    tests++; if (o_rdata !== 64'hFFFF_FFFF_8765_4321) begin fails++; $display("FAIL ld32s_hi_data got %h want ffffffff87654321", o_rdata); end
    run_req(1'b0, 1'b1, 1'b0, 64'h8, 64'h0);
    tests++; if (o_rdata !== 64'h8765_4321_DEAD_BEEF || o_resp_at !== 2) begin fails++; $display("FAIL ld64 got %h at %0d want 87654321deadbeef at 2", o_rdata, o_resp_at); end
  endtask

  task automatic test_store32;
    run_req(1'b1, 1'b0, 1'b0, 64'h4, 64'h0000_0000_CAFE_F00D);
    tests++; if (o_we_cnt !== 1 || o_we_at !== 2) begin fails++; $display("FAIL st32_we got cnt=%0d at=%0d want 1/2", o_we_cnt, o_we_at); end
    tests++; if (o_we_a !== 64'h0) begin fails++; $display("FAIL st32_addr got %h want 0", o_we_a); end
    tests++; if (mem[0] !== 64'hCAFE_F00D_3333_4444) begin fails++; $display("FAIL st32_mem got %h want cafef00d33334444", mem[0]); end
    tests++; if (o_resp_at !== 3 || o_rdata !== 64'h0 || o_err !== 1'b0) begin fails++; $display("FAIL st32_resp got at=%0d d=%h e=%b want 3/0/0", o_resp_at, o_rdata, o_err); end
  endtask

  task automatic test_store64;
    run_req(1'b1, 1'b1, 1'b0, 64'h8, 64'h0123_4567_89AB_CDEF);
    tests++; if (o_we_cnt !== 1 || o_we_at !== 1) begin fails++; $display("FAIL st64_we got cnt=%0d at=%0d want 1/1", o_we_cnt, o_we_at); end
    tests++; if (mem[1] !== 64'h0123_4567_89AB_CDEF) begin fails++; $display("FAIL st64_mem got %h want 0123456789abcdef", mem[1]); end
    tests++; if (o_resp_at !== 2 || o_rdata !== 64'h0) begin fails++; $display("FAIL st64_resp got at=%0d d=%h want 2/0", o_resp_at, o_rdata); end
    // Low-half RMW back to back
    run_req(1'b1, 1'b0, 1'b0, 64'h8, 64'hFFFF_FFFF_5555_AAAA);
    tests++; if (mem[1] !== 64'h0123_4567_5555_AAAA) begin fails++; $display("FAIL st32_lo_mem got %h want 012345675555aaaa", mem[1]); end
  endtask

  task automatic test_misaligned;
    run_req(1'b1, 1'b0, 1'b0, 64'h2, 64'h0000_0000_1234_5678);
    tests++; if (o_err !== 1'b1 || o_resp_at !== 2 || o_rdata !== 64'h0) begin fails++; $display("FAIL err_st32 got e=%b at=%0d d=%h want 1/2/0", o_err, o_resp_at, o_rdata); end
    tests++; if (o_we_cnt !== 0) begin fails++; $display("FAIL err_st32_we got %0d want 0", o_we_cnt); end
    run_req(1'b0, 1'b1, 1'b0, 64'h4, 64'h0);
    tests++; if (o_err !== 1'b1 || o_resp_at !== 2 || o_rdata !== 64'h0 || o_we_cnt !== 0) begin fails++; $display("FAIL err_ld64 got e=%b at=%0d d=%h we=%0d want 1/2/0/0", o_err, o_resp_at, o_rdata, o_we_cnt); end
    tests++; if (mem[0] !== 64'hCAFE_F00D_3333_4444 || mem[1] !== 64'h0123_4567_5555_AAAA) begin fails++; $display("FAIL err_mem got %h %h want unchanged", mem[0], mem[1]); end
    // Follow-up good load must not carry the error flag
    run_req(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    tests++; if (o_err !== 1'b0 || o_rdata !== 64'h0000_0000_3333_4444) begin fails++; $display("FAIL post_err_ld got e=%b d=%h want 0/0000000033334444", o_err, o_rdata); end
  endtask

  task automatic test_reset_abort;
    int we_seen, rv_seen;
    we_seen = 0; rv_seen = 0;
    @(negedge clk);
    req_we = 1'b1; req_dw = 1'b0; req_signed = 1'b0; req_addr = 64'h0;
    req_wdata = 64'h0000_0000_BAD0_BAD0; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);            // RMW_RD cycle
    req_valid = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (mem_we) we_seen++;
      if (resp_valid) rv_seen++;
      if (k == 1) reset = 1'b0;
      @(negedge clk);
    end
    tests++; if (we_seen !== 0 || rv_seen !== 0) begin fails++; $display("FAIL abort_activity got we=%0d rv=%0d want 0/0", we_seen, rv_seen); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL abort_ready got %b want 1", req_ready); end
    tests++; if (mem[0] !== 64'hCAFE_F00D_3333_4444) begin fails++; $display("FAIL abort_mem got %h want cafef00d33334444", mem[0]); end
  endtask

  initial begin
    mem[0] = 64'h1111_2222_3333_4444;
    mem[1] = 64'h8765_4321_DEAD_BEEF;
    mem[2] = 64'h0;
    mem[3] = 64'h0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_dw = 1'b0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset;
    test_load;
    test_store32;
    test_store64;
    test_misaligned;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
